// File: rtl/pulse_stretch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretch_queue_pkg
//  Description : Shared definitions for pulse_stretch_queue: FSM state
//                encodings, the state enum built on them, and constant
//                helper functions used to size the phase counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_stretch_queue_pkg;

  // FSM state encodings
  localparam logic [1:0] IDLE = 2'd0;  // no pulse in flight
  localparam logic [1:0] HIGH = 2'd1;  // o_pulse driven high
  localparam logic [1:0] LOW  = 2'd2;  // mandatory low gap after a pulse

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_HIGH = HIGH,
    ST_LOW  = LOW
  } state_t;

  // Ceiling log2 for elaboration-time sizing. The result is never below 1,
  // so a counter declared with it always has at least one bit.
  function automatic int CLOG2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic int MAX2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : pulse_stretch_queue_pkg
`default_nettype wire

// File: rtl/pulse_stretch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_stretch_queue
//  Description : Source-domain pulse stretcher. Each single-cycle i_event
//                becomes one o_pulse that is HOLD cycles high followed by at
//                least GAP cycles low, so a slower destination synchroniser
//                can catch it. Events arriving while a pulse is in flight are
//                counted and replayed in order; once the backlog counter is
//                full, further events are dropped and o_overflow is set.
//  Revision    : 1.0 - initial release
//
//  Ports
//    i_clk        in   1      source-domain clock
//    rst          in   1      asynchronous reset, active low
//    i_event      in   1      event strobe, every high cycle is one event
//    i_clear_ovf  in   1      clears o_overflow (a coincident drop wins)
//    o_pulse      out  1      stretched pulse level, direct flop output
//    o_busy       out  1      high while a pulse or its gap is in progress
//    o_pending    out  CNT_W  events accepted but not yet launched
//    o_overflow   out  1      sticky: at least one event was lost
// ============================================================================
module pulse_stretch_queue
  import pulse_stretch_queue_pkg::*;
#(
  parameter int HOLD  = 4,
  parameter int GAP   = 4,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             i_event,
  input  logic             i_clear_ovf,
  output logic             o_pulse,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_pending,
  output logic             o_overflow
);

  localparam int PH_W = CLOG2(MAX2(HOLD, GAP) + 1);

  // Phase counter counts down to zero; zero marks the last cycle of a phase.
  localparam logic [PH_W-1:0]  c_HOLD_LAST = PH_W'(HOLD - 1);
  localparam logic [PH_W-1:0]  c_GAP_LAST  = PH_W'(GAP - 1);
  localparam logic [CNT_W-1:0] c_PEND_MAX  = '1;

  state_t           r_state;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_pending;
  logic             r_pulse;
  logic             r_busy;
  logic             r_overflow;

  logic w_idle;
  logic w_low_done;
  logic w_pend_nz;
  logic w_relaunch;
  logic w_evt_launches;
  logic w_inc;
  logic w_dec;
  logic w_full;
  logic w_drop;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_low_done = (r_state == ST_LOW) && (r_phase == '0);
  assign w_pend_nz  = (r_pending != '0);

  // End of the gap: launch again if there is backlog, or if a fresh event
  // arrives exactly in this last low cycle.
  assign w_relaunch = w_low_done && (w_pend_nz || i_event);

  // The incoming event itself starts the pulse only from IDLE, or at the end
  // of a gap with an empty backlog; otherwise it must be queued.
  assign w_evt_launches = i_event && (w_idle || (w_low_done && !w_pend_nz));

  assign w_inc  = i_event && !w_evt_launches;
  assign w_dec  = w_low_done && w_pend_nz;
  assign w_full = (r_pending == c_PEND_MAX);

  // A queued event coinciding with a backlog launch frees its own slot, so
  // it is only lost when the counter is full and nothing leaves this cycle.
  assign w_drop = w_inc && !w_dec && w_full;

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_phase    <= '0;
      r_pending  <= '0;
      r_pulse    <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // Pulse/gap sequencer
      case (r_state)
        ST_IDLE: begin
          if (i_event) begin
            r_state <= ST_HIGH;
            r_phase <= c_HOLD_LAST;
            r_pulse <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (r_phase == '0) begin
            r_state <= ST_LOW;
            r_phase <= c_GAP_LAST;
            r_pulse <= 1'b0;
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        ST_LOW: begin
          if (r_phase == '0) begin
            if (w_relaunch) begin
              r_state <= ST_HIGH;
              r_phase <= c_HOLD_LAST;
              r_pulse <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_phase <= r_phase - PH_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_phase <= '0;
          r_pulse <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      // Saturating backlog counter; a simultaneous increment and decrement
      // leaves it unchanged.
      if (w_inc && !w_dec && !w_full) begin
        r_pending <= r_pending + CNT_W'(1);
      end else if (w_dec && !w_inc) begin
        r_pending <= r_pending - CNT_W'(1);
      end

      // Sticky loss flag; a drop in the same cycle as a clear keeps it set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (i_clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign o_pulse    = r_pulse;
  assign o_busy     = r_busy;
  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule : pulse_stretch_queue
`default_nettype wire
